dff_rr_write_arbiter: RTL and testbench



---
 rtl/dff_rr_write_arbiter.sv | 100 ++++++++++
 tb/tb_dff_rr_write_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dff_rr_write_arbiter.sv
// Round-robin write arbiter for a shared WIDTH-bit register: one grant per round, then a hold window.
// Optional even-parity output dout_par is enabled by defining DFF_ARB_PARITY_EN.
module dff_rr_write_arbiter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         gnt,
    output logic [WIDTH-1:0]   dout,
    output logic [1:0]         owner,
    output logic               valid
`ifdef DFF_ARB_PARITY_EN
    ,
    output logic               dout_par
`endif
);

    typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

    // Guarded so HOLD_CYCLES == 0 never produces an underflowed load value.
    localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

    state_e           state;
    logic [1:0]       ptr;
    logic [7:0]       hold_cnt;
    logic [WIDTH-1:0] lane [4];
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             found;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign lane[i] = wdata[i*WIDTH +: WIDTH];
    end

    // First set request bit scanning from ptr upward, wrapping modulo 4.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            gnt      <= '0;
            dout     <= '0;
            owner    <= '0;
            ptr      <= '0;
            valid    <= 1'b0;
            hold_cnt <= '0;
`ifdef DFF_ARB_PARITY_EN
            dout_par <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (|req) begin
                        state <= StGrant;
                        gnt   <= 4'b0001 << win;
                        dout  <= lane[win];
                        owner <= win;
                        ptr   <= win + 2'd1;
                        valid <= 1'b1;
`ifdef DFF_ARB_PARITY_EN
                        dout_par <= ^lane[win];
`endif
                    end
                end
                StGrant: begin
                    gnt <= '0;
                    if (HOLD_CYCLES > 0) begin
                        state    <= StHold;
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        state <= StIdle;
                    end
                end
                StHold: begin
                    if (hold_cnt == 8'd0) begin
                        state <= StIdle;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_rr_write_arbiter.sv
// Directed bench for dff_rr_write_arbiter; grants are checked against a queue of expected results.
module tb_dff_rr_write_arbiter;

    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [3:0]       gnt;
        logic [WIDTH-1:0] dout;
        logic [1:0]       owner;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         gnt;
    logic [WIDTH-1:0]   dout;
    logic [1:0]         owner;
    logic               valid;
`ifdef DFF_ARB_PARITY_EN
    logic               dout_par;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    dff_rr_write_arbiter #(
        .WIDTH       (WIDTH),
        .HOLD_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .dout     (dout),
        .owner    (owner),
        .valid    (valid)
`ifdef DFF_ARB_PARITY_EN
        ,
        .dout_par (dout_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] w, input logic [WIDTH-1:0] d);
        exp_t e;
        e.gnt   = 4'b0001 << w;
        e.dout  = d;
        e.owner = w;
        sb.push_back(e);
    endtask

    // Scoreboard side: every visible grant must match the oldest expected entry.
    always @(posedge clk) begin
        #1;
        check("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
        if (gnt !== 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_gnt", 64'(gnt), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_gnt", 64'(gnt), 64'(e.gnt));
                check("sb_dout", 64'(dout), 64'(e.dout));
                check("sb_owner", 64'(owner), 64'(e.owner));
            end
        end
    end

    initial begin
        rst   = 1'b1;
        req   = 4'hF;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset held with all requests asserted.
        tick(2);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
`ifdef DFF_ARB_PARITY_EN
        check("rst_par", 64'(dout_par), 64'd0);
`endif
        rst = 1'b0;
        req = 4'h0;
        tick(1);
        check("idle_valid", 64'(valid), 64'd0);

        // Single requester 2.
        wdata[2*WIDTH +: WIDTH] = 8'hA5;
        req = 4'b0100;
        push(2'd2, 8'hA5);
        tick(1);
        check("single_gnt", 64'(gnt), 64'b0100);
        check("single_valid", 64'(valid), 64'd1);
        req = 4'h0;
        tick(1);
        check("single_gnt_drop", 64'(gnt), 64'd0);
        check("single_dout_hold", 64'(dout), 64'hA5);
        tick(2);

        // All requesting: ptr is 3 after the single grant, so 3,0,1,2,3 with 4-cycle spacing.
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] w;
            w = 2'(i + 3);
            push(w, 8'h11 * (8'(w) + 8'd1));
            tick(1);
            check("fair_gnt", 64'(gnt), 64'(4'b0001 << w));
            for (int j = 0; j < 3; j++) begin
                if (i == 4 && j == 0) req = 4'h0;
                tick(1);
                check("fair_gap", 64'(gnt), 64'd0);
            end
        end

        // Wrap: ptr is 0 after owner 3; requester 0 beats 3, then 3 follows.
        req = 4'b1001;
        push(2'd0, 8'h11);
        tick(1);
        check("wrap_first", 64'(owner), 64'd0);
        req = 4'b1000;
        tick(3);
        push(2'd3, 8'h44);
        tick(1);
        check("wrap_second", 64'(owner), 64'd3);
        req = 4'h0;
        tick(3);

        // Reset during the second hold cycle.
        wdata[1*WIDTH +: WIDTH] = 8'h5A;
        req = 4'b0010;
        push(2'd1, 8'h5A);
        tick(1);
        req = 4'h0;
        tick(2);
        rst = 1'b1;
        req = 4'b0001;
        wdata[0 +: WIDTH] = 8'h3C;
        tick(1);
        check("midrst_dout", 64'(dout), 64'd0);
        check("midrst_gnt", 64'(gnt), 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        rst = 1'b0;
        push(2'd0, 8'h3C);
        tick(1);
        check("postrst_gnt", 64'(gnt), 64'b0001);
        req = 4'h0;
        tick(3);

`ifdef DFF_ARB_PARITY_EN
        wdata[0 +: WIDTH] = 8'h07;
        req = 4'b0001;
        push(2'd0, 8'h07);
        tick(1);
        check("par_07", 64'(dout_par), 64'd1);
        req = 4'h0;
        tick(3);
        wdata[0 +: WIDTH] = 8'h03;
        req = 4'b0001;
        push(2'd0, 8'h03);
        tick(1);
        check("par_03", 64'(dout_par), 64'd0);
        req = 4'h0;
        tick(3);
`endif

        tick(2);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
